xs3_convert_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 2-digit BCD-to-Excess-3 adder (+8'h33) among NREQ requesters.
- Typical requesters are the hours, minutes and seconds display paths of the Spartan-3 clock.
- Each requester presents a packed 2-digit BCD byte and holds a request until it sees its done pulse.
- The block validates both digits, converts the byte, and returns the result with the requester index.

---
 rtl/xs3_pkg.sv | 26 ++
 rtl/xs3_core.sv | 23 ++
 rtl/xs3_convert_arbiter.sv | 156 +++++++++++++++
 tb/tb_xs3_convert_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// Shared definitions for the Excess-3 conversion arbiter: FSM states, bias
// constants and the per-digit validity check used by the converter.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] XS3_BIAS = 8'h33;
    localparam logic [7:0] ERR_CODE = 8'hFF;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] XS3_MIN = 4'd3;
    localparam logic [3:0] XS3_MAX = 4'd12;

    // A BCD digit is 0..9; an Excess-3 digit is the same range shifted by 3.
    function automatic logic digit_valid(input logic [3:0] digit, input logic dir);
        if (dir)
            return (digit >= XS3_MIN) && (digit <= XS3_MAX);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/xs3_core.sv
// Combinational 2-digit converter: BCD -> Excess-3 (dir=0) or Excess-3 -> BCD
// (dir=1). Invalid operands yield ERR_CODE with valid low.
module xs3_core
    import xs3_pkg::*;
(
    input  logic [7:0] op,
    input  logic       dir,
    output logic [7:0] res,
    output logic       valid
);

    // With every digit in range no nibble carries or borrows, so one 8-bit add does both digits.
    always_comb begin
        valid = digit_valid(op[7:4], dir) && digit_valid(op[3:0], dir);
        if (!valid)
            res = ERR_CODE;
        else if (dir)
            res = op - XS3_BIAS;
        else
            res = op + XS3_BIAS;
    end

endmodule

// File: rtl/xs3_convert_arbiter.sv
// Round-robin arbiter sharing one xs3_core among NREQ requesters.
// Optional decode direction is enabled by defining XS3_DECODE_EN.
module xs3_convert_arbiter
    import xs3_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] din,
`ifdef XS3_DECODE_EN
    input  logic [NREQ-1:0]   dir,
`endif
    output logic [NREQ-1:0]   grant,
    output logic              done,
    output logic [7:0]        dout,
    output logic [IDW-1:0]    dout_id,
    output logic              err,
    output logic              busy
);

    state_t state;
    state_t next_state;

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_r;
    logic [7:0]      op_r;
    logic [7:0]      res_r;
    logic            err_r;
    logic [IDW-1:0]  id_r;

    logic [IDW-1:0]  pick_idx;
    logic            pick_found;
    int              pick_cand;
    logic [7:0]      op_sel;
    logic [7:0]      core_res;
    logic            core_valid;
    logic            dir_r;

    // First requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        pick_cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            pick_cand = int'(rr_ptr) + i;
            if (pick_cand >= NREQ)
                pick_cand = pick_cand - NREQ;
            if (!pick_found && req[pick_cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(pick_cand);
            end
        end
    end

    always_comb begin
        op_sel = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i))
                op_sel = din[8*i +: 8];
        end
    end

`ifdef XS3_DECODE_EN
    logic dir_sel;

    always_comb begin
        dir_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i))
                dir_sel = dir[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dir_r <= 1'b0;
        else if (state == LATCH)
            dir_r <= dir_sel;
    end
`else
    assign dir_r = 1'b0;
`endif

    xs3_core u_core (
        .op    (op_r),
        .dir   (dir_r),
        .res   (core_res),
        .valid (core_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (|req) next_state = LATCH;
            LATCH:   next_state = CONV;
            CONV:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
        busy = (state != IDLE);
    end

    // Result registers load on entry to DONE and hold until the next DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_r   <= '0;
            op_r      <= 8'h00;
            res_r     <= 8'h00;
            err_r     <= 1'b0;
            id_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        grant_r   <= NREQ'(1) << pick_idx;
                    end
                end
                LATCH: op_r <= op_sel;
                CONV: begin
                    res_r <= core_res;
                    err_r <= !core_valid;
                    id_r  <= grant_idx;
                end
                DONE: begin
                    grant_r <= '0;
                    rr_ptr  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant   = grant_r;
    assign dout    = res_r;
    assign dout_id = id_r;
    assign err     = err_r;

endmodule

// File: tb/tb_xs3_convert_arbiter.sv
// Self-checking bench for xs3_convert_arbiter: vector table, corner-case
// sequences and randomized transactions against a digit-level reference model.
module tb_xs3_convert_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   dir_v;
    logic [NREQ-1:0]   grant;
    logic              done;
    logic [7:0]        dout;
    logic [IDW-1:0]    dout_id;
    logic              err;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int model_rr = 0;

    typedef struct {
        logic [NREQ-1:0] r;
        logic [7:0]      op;
        int              id;
        logic [7:0]      exp_dout;
        logic            exp_err;
    } vec_t;

    vec_t vecs[8];

    xs3_convert_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
`ifdef XS3_DECODE_EN
        .dir     (dir_v),
`endif
        .grant   (grant),
        .done    (done),
        .dout    (dout),
        .dout_id (dout_id),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Digit-level reference: {err, result}.
    function automatic logic [8:0] ref_convert(input logic [7:0] op, input logic d);
        int t, u, lo, hi, bias;
        t    = int'(op[7:4]);
        u    = int'(op[3:0]);
        lo   = d ? 3 : 0;
        hi   = d ? 12 : 9;
        bias = d ? -3 : 3;
        if (t < lo || t > hi || u < lo || u > hi)
            return {1'b1, 8'hFF};
        return {1'b0, 4'(t + bias), 4'(u + bias)};
    endfunction

    function automatic int ref_pick(input int rr, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ])
                return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rand_byte(input logic d);
        int lo, hi;
        lo = d ? 3 : 0;
        hi = d ? 12 : 9;
        if ($urandom_range(0, 4) == 0)
            return 8'($urandom);
        return {4'($urandom_range(lo, hi)), 4'($urandom_range(lo, hi))};
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] ops,
                                 input logic [NREQ-1:0] dirs);
        req   = r;
        din   = ops;
        dir_v = dirs;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_rr = 0;
    endtask

    // Starts in an IDLE cycle; ends one cycle after done, back in IDLE.
    task automatic run_txn(input string tag, input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] ops,
                           input logic [NREQ-1:0] dirs, input int exp_id, input logic [7:0] exp_dout,
                           input logic exp_err, input bit perturb);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 0;
        applyStimulus(r, ops, dirs);
        while (!seen && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1)
                checkOutput({tag, " grant"}, 32'(grant), 32'(1) << exp_id);
            if (cyc == 2 && perturb) begin
                req = '0;
                din = ~din;
            end
            if (done)
                seen = 1;
        end
        checkOutput({tag, " latency"}, cyc, 3);
        checkOutput({tag, " id"}, 32'(dout_id), exp_id);
        checkOutput({tag, " dout"}, 32'(dout), 32'(exp_dout));
        checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
        model_rr = (exp_id + 1) % NREQ;
        req = '0;
        @(posedge clk);
        #1;
        checkOutput({tag, " idle"}, {busy, done, 1'b0, 29'(grant)}, 0);
        checkOutput({tag, " hold"}, {err, dout}, {exp_err, exp_dout});
    endtask

    initial begin
        logic [8*NREQ-1:0] ops;
        logic [NREQ-1:0]   r;
        logic [NREQ-1:0]   dirs;
        logic [8:0]        expv;
        int                id;
        int                cyc;
        int                n;
        int                ids[4];
        logic [7:0]        douts[4];
        int                when[4];
        int                exp_ids[4];
        logic [7:0]        exp_douts[4];
        bit                saw_done;

        req   = '0;
        din   = '0;
        dir_v = '0;
        do_reset();
        checkOutput("reset", {15'd0, grant, done, dout, dout_id, err, busy}, 0);

        vecs[0] = '{3'b001, 8'h45, 0, 8'h78, 1'b0};
        vecs[1] = '{3'b010, 8'h00, 1, 8'h33, 1'b0};
        vecs[2] = '{3'b100, 8'h99, 2, 8'hCC, 1'b0};
        vecs[3] = '{3'b010, 8'h9A, 1, 8'hFF, 1'b1};
        vecs[4] = '{3'b010, 8'h12, 1, 8'h45, 1'b0};
        vecs[5] = '{3'b001, 8'hA0, 0, 8'hFF, 1'b1};
        vecs[6] = '{3'b100, 8'h09, 2, 8'h3C, 1'b0};
        vecs[7] = '{3'b001, 8'h90, 0, 8'hC3, 1'b0};
        for (int i = 0; i < 8; i++) begin
            ops = 24'hA5A5A5;
            ops[8*vecs[i].id +: 8] = vecs[i].op;
            run_txn($sformatf("vec%0d", i), vecs[i].r, ops, '0, vecs[i].id,
                    vecs[i].exp_dout, vecs[i].exp_err, 1'b0);
        end

        // All three requests held: strict rotation, one result every 4 cycles.
        do_reset();
        exp_ids   = '{0, 1, 2, 0};
        exp_douts = '{8'h45, 8'h8C, 8'h33, 8'h45};
        applyStimulus(3'b111, {8'h00, 8'h59, 8'h12}, '0);
        cyc = 0;
        n   = 0;
        while (n < 4 && cyc < 24) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ids[n]   = int'(dout_id);
                douts[n] = dout;
                when[n]  = cyc;
                n++;
            end
        end
        req = '0;
        checkOutput("held count", n, 4);
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("held id%0d", k), ids[k], exp_ids[k]);
            checkOutput($sformatf("held dout%0d", k), 32'(douts[k]), 32'(exp_douts[k]));
            checkOutput($sformatf("held cycle%0d", k), when[k], 3 + 4 * k);
        end
        @(posedge clk);
        #1;
        checkOutput("held idle", 32'(busy), 0);
        model_rr = 1;

        // Reset in CONV drops the transaction and the pointer.
        run_txn("pre-rst", 3'b010, {8'h00, 8'h34, 8'h00}, '0, 1, 8'h67, 1'b0, 1'b0);
        applyStimulus(3'b100, {8'h21, 8'h00, 8'h00}, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst mid", {grant, done, busy, dout}, 0);
        req = '0;
        saw_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done)
                saw_done = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (done)
            saw_done = 1;
        checkOutput("rst no done", 32'(saw_done), 0);
        model_rr = 0;
        run_txn("post-rst", 3'b111, {8'h11, 8'h22, 8'h33}, '0, 0, 8'h66, 1'b0, 1'b0);

        // Request dropped and operand changed mid-transaction.
        run_txn("drop", 3'b100, {8'h27, 8'h00, 8'h00}, '0, 2, 8'h5A, 1'b0, 1'b1);
        run_txn("after-drop", 3'b101, {8'h88, 8'h00, 8'h64}, '0, 0, 8'h97, 1'b0, 1'b0);

`ifdef XS3_DECODE_EN
        run_txn("dec ok", 3'b001, {8'h00, 8'h00, 8'hCC}, 3'b001, 0, 8'h99, 1'b0, 1'b0);
        run_txn("dec bad", 3'b001, {8'h00, 8'h00, 8'h20}, 3'b001, 0, 8'hFF, 1'b1, 1'b0);
`endif

        for (int it = 0; it < 150; it++) begin
            r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
`ifdef XS3_DECODE_EN
            dirs = NREQ'($urandom);
`else
            dirs = '0;
`endif
            for (int k = 0; k < NREQ; k++)
                ops[8*k +: 8] = rand_byte(dirs[k]);
            if (r == '0) begin
                applyStimulus(r, ops, dirs);
                repeat (2) @(posedge clk);
                #1;
                checkOutput($sformatf("rnd%0d quiet", it), {busy, done}, 0);
            end else begin
                id   = ref_pick(model_rr, r);
                expv = ref_convert(ops[8*id +: 8], dirs[id]);
                run_txn($sformatf("rnd%0d", it), r, ops, dirs, id, expv[7:0], expv[8],
                        ($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
